// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Holds MAR/MDR and turns the control unit's strobes into a
//            req/ack RAM transaction, with stall, done and error reporting.
//            Optional wait timeout enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              MDR_read,
    input  logic              RAM_write,
    output logic [DATA_W-1:0] MDR_q,
    output logic              Mem_wait,
    output logic              Mem_done,
    output logic              Mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must lie in 2..255");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              rd_prev_q, rd_prev_d;
    logic              wr_prev_q, wr_prev_d;
    logic              err_q, err_d;
    logic              rd_start;
    logic              wr_start;

`ifdef MEM_TIMEOUT_EN
    // Last count value before giving up; the wait ends after TIMEOUT-1 unacked cycles.
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 2);
    logic [7:0] cnt_q, cnt_d;
`endif

    assign rd_start = MDRin & MDR_read & ~rd_prev_q;
    assign wr_start = RAM_write & ~wr_prev_q;

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        err_d     = err_q;
        rd_prev_d = MDRin & MDR_read;
        wr_prev_d = RAM_write;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (MARin) begin
                    mar_d = BusMuxOut[ADDR_W-1:0];
                end
                if (MDRin && !MDR_read) begin
                    mdr_d = BusMuxOut;
                end
                if (wr_start) begin
                    state_d = WR_REQ;
                    // A simultaneous read request is dropped and flagged.
                    if (rd_start) begin
                        err_d = 1'b1;
                    end
                end else if (rd_start) begin
                    state_d = RD_REQ;
                end
`ifdef MEM_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            RD_REQ, WR_REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (state_q == RD_REQ) begin
                        mdr_d = mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            err_q     <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // All outputs decode purely from registers.
    assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we    = (state_q == WR_REQ);
    assign Mem_wait  = mem_req;
    assign Mem_done  = (state_q == DONE);
    assign Mem_err   = err_q;
    assign MDR_q     = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed and random checks of mem_access_unit against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic [DATA_W-1:0] BusMuxOut = '0;
    logic              MARin = 1'b0;
    logic              MDRin = 1'b0;
    logic              MDR_read = 1'b0;
    logic              RAM_write = 1'b0;
    logic [DATA_W-1:0] MDR_q;
    logic              Mem_wait;
    logic              Mem_done;
    logic              Mem_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending transaction (read or write) with its age.
    int                m_phase;      // 0 idle, 1 waiting for ack, 2 done pulse
    bit                m_is_wr;
    int                m_age;
    bit                m_rd_lvl, m_wr_lvl, m_err;
    logic [ADDR_W-1:0] m_mar;
    logic [DATA_W-1:0] m_mdr;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .BusMuxOut(BusMuxOut), .MARin(MARin),
        .MDRin(MDRin), .MDR_read(MDR_read), .RAM_write(RAM_write), .MDR_q(MDR_q),
        .Mem_wait(Mem_wait), .Mem_done(Mem_done), .Mem_err(Mem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_is_wr = 0; m_age = 0;
        m_rd_lvl = 0; m_wr_lvl = 0; m_err = 0;
        m_mar = '0; m_mdr = '0;
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_edge();
        bit rd_new, wr_new;
        rd_new = (MDRin && MDR_read) && !m_rd_lvl;
        wr_new = RAM_write && !m_wr_lvl;
        m_rd_lvl = MDRin && MDR_read;
        m_wr_lvl = RAM_write;
        if (m_phase == 0) begin
            if (MARin) m_mar = BusMuxOut[ADDR_W-1:0];
            if (MDRin && !MDR_read) m_mdr = BusMuxOut;
            if (wr_new || rd_new) begin
                m_phase = 1;
                m_is_wr = wr_new;
                m_age   = 0;
                if (wr_new && rd_new) m_err = 1;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (mem_ack) begin
                if (!m_is_wr) m_mdr = mem_rdata;
                m_phase = 2;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_age == TIMEOUT - 1) begin
                m_phase = 2;
                m_err   = 1;
            end
`endif
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".req"},   32'(mem_req),   32'(m_phase == 1));
        check({tag, ".we"},    32'(mem_we),    32'(m_phase == 1 && m_is_wr));
        check({tag, ".wait"},  32'(Mem_wait),  32'(m_phase == 1));
        check({tag, ".done"},  32'(Mem_done),  32'(m_phase == 2));
        check({tag, ".err"},   32'(Mem_err),   32'(m_err));
        check({tag, ".addr"},  32'(mem_addr),  32'(m_mar));
        check({tag, ".mdr"},   MDR_q,          m_mdr);
        check({tag, ".wdata"}, mem_wdata,      m_mdr);
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs compared.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge Clock);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        MARin = 0; MDRin = 0; MDR_read = 0; RAM_write = 0; mem_ack = 0;
    endtask

    initial begin
        int req_cnt, done_cnt, done_at;
        bit wdata_ok;
        logic [DATA_W-1:0] mdr_before;

        model_reset();
        #12;
        compare_all("reset");
        check("reset.req_const", 32'(mem_req), 32'd0);
        @(negedge Clock);
        Reset_n = 1;

        // Read with zero wait states.
        MARin = 1; BusMuxOut = 32'h00A;
        cyc("rd0.mar");
        MARin = 0; MDRin = 1; MDR_read = 1;
        cyc("rd0.start");
        check("rd0.addr", 32'(mem_addr), 32'h00A);
        check("rd0.we",   32'(mem_we),   32'd0);
        MDRin = 0; MDR_read = 0; mem_ack = 1; mem_rdata = 32'h12345678;
        cyc("rd0.ack");
        check("rd0.done", 32'(Mem_done), 32'd1);
        check("rd0.mdr",  MDR_q,         32'h12345678);
        mem_ack = 0;
        cyc("rd0.idle");
        check("rd0.done_pulse", 32'(Mem_done), 32'd0);

        // Write held for four cycles, acknowledged on the third request cycle.
        MDRin = 1; BusMuxOut = 32'hCAFEF00D;
        cyc("wr.mdr");
        MDRin = 0; MARin = 1; BusMuxOut = 32'h1FF;
        cyc("wr.mar");
        MARin = 0;
        req_cnt = 0; done_cnt = 0; wdata_ok = 1;
        for (int i = 0; i < 8; i++) begin
            RAM_write = (i < 4);
            mem_ack   = (i == 3);
            cyc("wr.run");
            if (mem_req) begin
                req_cnt++;
                if (mem_wdata !== 32'hCAFEF00D || mem_addr !== 9'h1FF || !mem_we) wdata_ok = 0;
            end
            if (Mem_done) done_cnt++;
        end
        check("wr.req_cycles", 32'(req_cnt),  32'd3);
        check("wr.done_count", 32'(done_cnt), 32'd1);
        check("wr.bus_values", 32'(wdata_ok), 32'd1);
        idle_inputs();

        // Read/write collision: write wins, error sticks.
        MDRin = 1; MDR_read = 1; RAM_write = 1;
        cyc("col.start");
        check("col.we",  32'(mem_we),  32'd1);
        check("col.err", 32'(Mem_err), 32'd1);
        idle_inputs(); mem_ack = 1;
        cyc("col.ack");
        mem_ack = 0;
        for (int i = 0; i < 4; i++) cyc("col.hold");
        check("col.err_sticky", 32'(Mem_err), 32'd1);

        // Bus loads while busy are ignored.
        MDRin = 1; MDR_read = 1;
        cyc("busy.start");
        mdr_before = MDR_q;
        MDR_read = 0; MARin = 1; BusMuxOut = 32'h055;
        cyc("busy.load");
        check("busy.addr", 32'(mem_addr), 32'h1FF);
        check("busy.mdr",  MDR_q,         mdr_before);
        MARin = 0; MDRin = 0; mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        cyc("busy.ack");
        mem_ack = 0;
        cyc("busy.done");
        MARin = 1;
        cyc("busy.reload");
        check("busy.addr_after", 32'(mem_addr), 32'h055);
        MARin = 0;
        cyc("busy.idle");

        // Asynchronous reset in the middle of a read.
        MDRin = 1; MDR_read = 1;
        cyc("rst.start");
        check("rst.req_before", 32'(mem_req), 32'd1);
        idle_inputs();
        #2 Reset_n = 0;
        #1;
        model_reset();
        check("rst.req_now", 32'(mem_req), 32'd0);
        compare_all("rst.regs");
        #2 Reset_n = 1;
        MARin = 1; BusMuxOut = 32'h003;
        cyc("rst.mar");
        MARin = 0; MDRin = 1; MDR_read = 1;
        cyc("rst.rd");
        MDRin = 0; MDR_read = 0;
        cyc("rst.wait");
        mem_ack = 1; mem_rdata = 32'h0BADBEEF;
        cyc("rst.ack");
        check("rst.mdr", MDR_q, 32'h0BADBEEF);
        mem_ack = 0;
        cyc("rst.idle");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            MARin     = ($urandom_range(3) == 0);
            MDRin     = ($urandom_range(2) == 0);
            MDR_read  = $urandom_range(1);
            RAM_write = ($urandom_range(3) == 0);
            mem_ack   = ($urandom_range(2) == 0);
            BusMuxOut = $urandom;
            mem_rdata = $urandom;
            cyc("rand");
        end
        idle_inputs();
        cyc("rand.drain1");
        cyc("rand.drain2");
        cyc("rand.drain3");

        // A read that is never acknowledged.
        MDRin = 1; MDR_read = 1;
        mdr_before = MDR_q;
        cyc("to.start");
        MDRin = 0; MDR_read = 0;
        done_at = 0;
        for (int i = 2; i <= 120; i++) begin
            cyc("to.wait");
            if (Mem_done && done_at == 0) done_at = i;
        end
`ifdef MEM_TIMEOUT_EN
        check("to.done_cycle", 32'(done_at), 32'(TIMEOUT));
        check("to.err",        32'(Mem_err), 32'd1);
        check("to.mdr",        MDR_q,        mdr_before);
`else
        check("to.no_done",    32'(done_at),  32'd0);
        check("to.still_wait", 32'(Mem_wait), 32'd1);
        mem_ack = 1;
        cyc("to.ack");
        mem_ack = 0;
        cyc("to.idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
